node_initiator: RTL and testbench



---
 rtl/node_initiator.sv | 173 +++++++++++++++++
 tb/tb_node_initiator.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/node_initiator.sv
// Initiating end of the ST/RD/RES node handshake: fans a start strobe out to two
// children, collects their results and reports a combined value upstream.
module node_initiator #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ST,
  input  logic [1:0]       OP,
  output logic             RD,
  output logic [WIDTH-1:0] RES,
  output logic             ERR,
  output logic             C_ST,
  input  logic             C_RD0,
  input  logic             C_RD1,
  input  logic [WIDTH-1:0] C_RES0,
  input  logic [WIDTH-1:0] C_RES1
);

  localparam int            CW      = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WAIT    = 2'd1;
  localparam logic [1:0] S_COMPUTE = 2'd2;

  localparam logic [1:0] OP_ADD  = 2'd0;
  localparam logic [1:0] OP_SUB  = 2'd1;
  localparam logic [1:0] OP_MAX  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic             rd_q, rd_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             err_q, err_d;
  logic             cst_q, cst_d;
  logic             ack0_q, ack0_d, ack1_q, ack1_d;
  logic             done0_q, done0_d, done1_q, done1_d;
  logic [WIDTH-1:0] lat0_q, lat0_d, lat1_q, lat1_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             st_old_q;

  logic             start;
  logic             both_done;
  logic             expired;
  logic [WIDTH-1:0] result;

  assign start     = ST && !st_old_q;
  assign both_done = done0_q && done1_q;
  assign expired   = (cnt_q == CNT_MAX);

  always_comb begin
    case (op_q)
      OP_ADD:  result = lat0_q + lat1_q;
      OP_SUB:  result = lat0_q - lat1_q;
      OP_MAX:  result = (lat0_q > lat1_q) ? lat0_q : lat1_q;
      default: result = lat0_q;
    endcase
  end

  always_comb begin
    // NOTE: every next-state signal defaults to its register so no path infers a latch.
    state_d = state_q;
    op_d    = op_q;
    rd_d    = rd_q;
    res_d   = res_q;
    err_d   = err_q;
    cst_d   = cst_q;
    ack0_d  = ack0_q;
    ack1_d  = ack1_q;
    done0_d = done0_q;
    done1_d = done1_q;
    lat0_d  = lat0_q;
    lat1_d  = lat1_q;
    cnt_d   = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = OP;
          rd_d    = 1'b0;
          err_d   = 1'b0;
          cst_d   = 1'b1;
          ack0_d  = 1'b0;
          ack1_d  = 1'b0;
          done0_d = 1'b0;
          done1_d = 1'b0;
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (!C_RD0) ack0_d = 1'b1;
        if (!C_RD1) ack1_d = 1'b1;
        // A child's result is captured only on the edge its handshake completes.
        if (ack0_q && C_RD0 && !done0_q) begin
          done0_d = 1'b1;
          lat0_d  = C_RES0;
        end
        if (ack1_q && C_RD1 && !done1_q) begin
          done1_d = 1'b1;
          lat1_d  = C_RES1;
        end
        if (ack0_q && ack1_q) cst_d = 1'b0;

        // Result is registered on entry to COMPUTE, so RD rises one edge after both dones.
        if (both_done) begin
          res_d   = result;
          rd_d    = 1'b1;
          cst_d   = 1'b0;
          state_d = S_COMPUTE;
        end else if (expired) begin
          cst_d   = 1'b0;
          err_d   = 1'b1;
          rd_d    = 1'b1;
          state_d = S_IDLE;
        end
      end

      S_COMPUTE: begin
        rd_d    = 1'b1;
        cst_d   = 1'b0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state updates use non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge CLK) begin
    st_old_q <= ST;
    if (RST) begin
      // NOTE: the latched child results are reset too; they are plain registers, not RAM.
      state_q <= S_IDLE;
      op_q    <= OP_ADD;
      rd_q    <= 1'b1;
      res_q   <= '0;
      err_q   <= 1'b0;
      cst_q   <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      lat0_q  <= '0;
      lat1_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      res_q   <= res_d;
      err_q   <= err_d;
      cst_q   <= cst_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      lat0_q  <= lat0_d;
      lat1_q  <= lat1_d;
      cnt_q   <= cnt_d;
    end
  end

  assign RD   = rd_q;
  assign RES  = res_q;
  assign ERR  = err_q;
  assign C_ST = cst_q;

endmodule

// File: tb/tb_node_initiator.sv
// Bench for node_initiator: two instances (long and short timeout) share a pair of
// behavioural child nodes; results are compared with a timing/arithmetic model.
module tb_node_initiator;

  typedef struct {
    int          d;      // cycles of extra delay before dropping RD
    int          low;    // cycles RD is held low
    logic [15:0] val;
    bit          never;  // never drops RD
    bit          scr;    // corrupt C_RES right after the handshake
  } child_cfg_t;

  typedef struct {
    logic [1:0]  op;
    logic [15:0] c0;
    logic [15:0] c1;
    logic [15:0] res;
  } vec_t;

  localparam int BIG = 1 << 20;

  logic        CLK;
  logic        rst;
  logic        st_a, st_b;
  logic [1:0]  op;
  logic        rd_a, rd_b, err_a, err_b, cst_a, cst_b;
  logic [15:0] res_a, res_b;
  logic [1:0]  c_rd;
  logic [15:0] c_res [2];

  bit          sel;
  bit          kill;
  child_cfg_t  cfg [2];
  int          cph [2];
  int          ccnt [2];
  logic [15:0] prev_res [2];

  int n_checks = 0;
  int n_fail   = 0;

  wire        rd_m  = sel ? rd_b  : rd_a;
  wire        err_m = sel ? err_b : err_a;
  wire        cst_m = sel ? cst_b : cst_a;
  wire [15:0] res_m = sel ? res_b : res_a;

  node_initiator #(.WIDTH(16), .TIMEOUT(255)) dut_a (
    .CLK(CLK), .RST(rst), .ST(st_a), .OP(op),
    .RD(rd_a), .RES(res_a), .ERR(err_a), .C_ST(cst_a),
    .C_RD0(c_rd[0]), .C_RD1(c_rd[1]), .C_RES0(c_res[0]), .C_RES1(c_res[1])
  );

  node_initiator #(.WIDTH(16), .TIMEOUT(8)) dut_b (
    .CLK(CLK), .RST(rst), .ST(st_b), .OP(op),
    .RD(rd_b), .RES(res_b), .ERR(err_b), .C_ST(cst_b),
    .C_RD0(c_rd[0]), .C_RD1(c_rd[1]), .C_RES0(c_res[0]), .C_RES1(c_res[1])
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Child node behaviour, evaluated just after each edge on the selected C_ST.
  task automatic step_child(input int n);
    if (kill) begin
      cph[n]   = 0;
      c_rd[n]  = 1'b1;
      c_res[n] = 16'h0;
      return;
    end
    case (cph[n])
      0: begin
        c_rd[n] = 1'b1;
        if (cst_m && !cfg[n].never) begin
          ccnt[n] = cfg[n].d;
          cph[n]  = 1;
        end
      end
      1: begin
        if (ccnt[n] == 0) begin
          c_rd[n] = 1'b0;
          ccnt[n] = cfg[n].low - 1;
          cph[n]  = 2;
        end else ccnt[n]--;
      end
      2: begin
        if (ccnt[n] == 0) begin
          c_res[n] = cfg[n].val;
          c_rd[n]  = 1'b1;
          cph[n]   = 3;
        end else ccnt[n]--;
      end
      default: begin
        if (cfg[n].scr) c_res[n] = ~cfg[n].val;
        if (!cst_m) cph[n] = 0;
      end
    endcase
  endtask

  initial begin
    c_rd = 2'b11;
    c_res[0] = 16'h0;
    c_res[1] = 16'h0;
    cph[0] = 0;
    cph[1] = 0;
    forever begin
      @(posedge CLK);
      #1;
      step_child(0);
      step_child(1);
    end
  end

  function automatic logic [15:0] ref_op(input logic [1:0] o, input logic [15:0] a,
                                         input logic [15:0] b);
    int ia = int'(a);
    int ib = int'(b);
    int r;
    case (o)
      2'd0:    r = (ia + ib) % 65536;
      2'd1:    r = (ia - ib + 65536) % 65536;
      2'd2:    r = (ia > ib) ? ia : ib;
      default: r = ia;
    endcase
    return 16'(r);
  endfunction

  // Cycle counts relative to the start edge: child done at 2+d+low, ack at 2+d.
  task automatic timing_model(input child_cfg_t a, input child_cfg_t b, input int tmo,
                              output int busy, output int cst, output bit err);
    int dn0 = a.never ? BIG : 2 + a.d + a.low;
    int dn1 = b.never ? BIG : 2 + b.d + b.low;
    int an0 = a.never ? BIG : 2 + a.d;
    int an1 = b.never ? BIG : 2 + b.d;
    int dmax = (dn0 > dn1) ? dn0 : dn1;
    int amax = (an0 > an1) ? an0 : an1;
    err  = (dmax > tmo);
    busy = err ? tmo + 1 : dmax + 1;
    cst  = (amax + 1 < busy) ? amax + 1 : busy;
  endtask

  task automatic set_st(input logic v);
    if (sel) st_b = v;
    else     st_a = v;
  endtask

  // mode 0: ST pulsed; 1: ST held high; 2: ST toggled while busy.
  task automatic run_txn(input string nm, input bit s, input logic [1:0] o,
                         input child_cfg_t a, input child_cfg_t b, input int mode,
                         input logic [15:0] good_res);
    int busy_e, cst_e, busy, cstn, guard, extra;
    bit err_e;
    logic [15:0] res_e;
    logic cur;
    timing_model(a, b, s ? 8 : 255, busy_e, cst_e, err_e);
    res_e = err_e ? prev_res[s] : good_res;

    @(negedge CLK);
    kill = 1'b1;
    @(negedge CLK);
    kill   = 1'b0;
    sel    = s;
    cfg[0] = a;
    cfg[1] = b;
    op     = o;
    set_st(1'b1);
    @(posedge CLK);
    #1;
    busy  = 0;
    cstn  = 0;
    guard = 0;
    while (rd_m === 1'b0 && guard < 1000) begin
      busy++;
      if (cst_m === 1'b1) cstn++;
      cur = s ? st_b : st_a;
      if (mode == 0)      set_st(1'b0);
      else if (mode == 2) set_st(~cur);
      @(posedge CLK);
      #1;
      guard++;
    end
    check({nm, "_bound"}, 32'(guard < 1000), 32'd1);
    check({nm, "_busy"},  busy,  busy_e);
    check({nm, "_cst_n"}, cstn,  cst_e);
    check({nm, "_err"},   32'(err_m), 32'(err_e));
    check({nm, "_res"},   32'(res_m), 32'(res_e));
    check({nm, "_cst0"},  32'(cst_m), 32'd0);
    if (mode != 0) begin
      set_st(1'b1);
      extra = 0;
      repeat (6) begin
        @(posedge CLK);
        #1;
        if (rd_m !== 1'b1) extra++;
      end
      check({nm, "_no_restart"}, extra, 0);
      check({nm, "_res_hold"}, 32'(res_m), 32'(res_e));
    end
    set_st(1'b0);
    prev_res[s] = res_e;
  endtask

  function automatic child_cfg_t mk(input int d, input int low, input logic [15:0] val,
                                    input bit never, input bit scr);
    child_cfg_t c;
    c.d = d; c.low = low; c.val = val; c.never = never; c.scr = scr;
    return c;
  endfunction

  vec_t vecs [6];

  initial begin
    child_cfg_t a, b;
    logic [1:0] o;
    rst  = 1'b1;
    st_a = 1'b0;
    st_b = 1'b0;
    op   = 2'd0;
    sel  = 1'b0;
    kill = 1'b0;
    cfg[0] = mk(0, 2, 16'h0, 1'b0, 1'b0);
    cfg[1] = mk(0, 2, 16'h0, 1'b0, 1'b0);
    prev_res[0] = 16'h0;
    prev_res[1] = 16'h0;

    vecs[0] = '{2'd0, 16'h1234, 16'h0F00, 16'h2134};
    vecs[1] = '{2'd1, 16'h0001, 16'h0002, 16'hFFFF};
    vecs[2] = '{2'd0, 16'hFFFF, 16'h0003, 16'h0002};
    vecs[3] = '{2'd2, 16'h8000, 16'h7FFF, 16'h8000};
    vecs[4] = '{2'd2, 16'h0005, 16'h9000, 16'h9000};
    vecs[5] = '{2'd3, 16'hBEEF, 16'h1111, 16'hBEEF};

    repeat (3) @(posedge CLK);
    #1;
    check("rst_rd",   32'({rd_a, rd_b}),   32'h3);
    check("rst_err",  32'({err_a, err_b}), 32'h0);
    check("rst_cst",  32'({cst_a, cst_b}), 32'h0);
    check("rst_res",  32'({res_a, res_b}), 32'h0);
    @(negedge CLK);
    rst = 1'b0;

    foreach (vecs[i])
      run_txn($sformatf("vec%0d", i), 1'b0, vecs[i].op,
              mk(0, 2, vecs[i].c0, 1'b0, 1'b0), mk(0, 2, vecs[i].c1, 1'b0, 1'b0),
              0, vecs[i].res);

    // Reset in the middle of WAIT.
    @(negedge CLK);
    kill = 1'b1;
    @(negedge CLK);
    kill = 1'b0;
    sel  = 1'b0;
    cfg[0] = mk(0, 2, 16'h1111, 1'b0, 1'b0);
    cfg[1] = mk(0, 2, 16'h2222, 1'b0, 1'b0);
    op   = 2'd0;
    st_a = 1'b1;
    @(posedge CLK);
    #1;
    st_a = 1'b0;
    check("midwait_busy", 32'({rd_a, cst_a}), 32'h1);
    repeat (2) @(posedge CLK);
    #1;
    rst = 1'b1;
    @(posedge CLK);
    #1;
    check("midrst_rd",  32'(rd_a),  32'd1);
    check("midrst_res", 32'(res_a), 32'd0);
    check("midrst_err", 32'(err_a), 32'd0);
    check("midrst_cst", 32'(cst_a), 32'd0);
    rst = 1'b0;
    prev_res[0] = 16'h0;
    prev_res[1] = 16'h0;
    run_txn("after_rst", 1'b0, 2'd0, mk(0, 2, 16'h0102, 1'b0, 1'b0),
            mk(0, 2, 16'h0304, 1'b0, 1'b0), 0, 16'h0406);

    // Skewed children; child0 corrupts its bus after handshaking.
    run_txn("skew_pass", 1'b0, 2'd3, mk(0, 2, 16'hA5A5, 1'b0, 1'b1),
            mk(6, 2, 16'h0F0F, 1'b0, 1'b0), 0, 16'hA5A5);
    run_txn("skew_add", 1'b0, 2'd0, mk(0, 2, 16'h1000, 1'b0, 1'b1),
            mk(6, 3, 16'h0234, 1'b0, 1'b0), 0, 16'h1234);
    run_txn("skew_rev", 1'b0, 2'd1, mk(5, 1, 16'h0010, 1'b0, 1'b0),
            mk(0, 4, 16'h0001, 1'b0, 1'b1), 0, 16'h000F);

    // Start-edge qualification.
    run_txn("st_hold", 1'b0, 2'd2, mk(1, 2, 16'h0042, 1'b0, 1'b0),
            mk(0, 3, 16'h0041, 1'b0, 1'b0), 1, 16'h0042);
    run_txn("st_toggle", 1'b0, 2'd0, mk(3, 2, 16'h0007, 1'b0, 1'b0),
            mk(1, 2, 16'h0008, 1'b0, 1'b0), 2, 16'h000F);

    // Short-timeout instance: abort, recovery and completion-vs-timeout boundary.
    run_txn("b_good", 1'b1, 2'd0, mk(0, 2, 16'h5000, 1'b0, 1'b0),
            mk(0, 2, 16'h0055, 1'b0, 1'b0), 0, 16'h5055);
    run_txn("b_tmo", 1'b1, 2'd0, mk(0, 2, 16'h1111, 1'b0, 1'b0),
            mk(0, 2, 16'h2222, 1'b1, 1'b0), 0, 16'h3333);
    run_txn("b_clr", 1'b1, 2'd3, mk(0, 2, 16'h0777, 1'b0, 1'b0),
            mk(0, 2, 16'h0001, 1'b0, 1'b0), 0, 16'h0777);
    run_txn("b_edge_ok", 1'b1, 2'd1, mk(0, 2, 16'h0009, 1'b0, 1'b0),
            mk(4, 2, 16'h0004, 1'b0, 1'b0), 0, 16'h0005);
    run_txn("b_edge_tmo", 1'b1, 2'd0, mk(5, 2, 16'h0100, 1'b0, 1'b0),
            mk(0, 2, 16'h0200, 1'b0, 1'b0), 0, 16'h0300);

    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(3));
      a = mk($urandom_range(5), $urandom_range(1, 4), 16'($urandom), 1'b0, 1'($urandom_range(1)));
      b = mk($urandom_range(5), $urandom_range(1, 4), 16'($urandom), 1'b0, 1'($urandom_range(1)));
      run_txn($sformatf("rnd_a%0d", i), 1'b0, o, a, b, 0, ref_op(o, a.val, b.val));
    end
    for (int i = 0; i < 30; i++) begin
      o = 2'($urandom_range(3));
      a = mk($urandom_range(6), $urandom_range(1, 3), 16'($urandom),
             ($urandom_range(5) == 0), 1'($urandom_range(1)));
      b = mk($urandom_range(6), $urandom_range(1, 3), 16'($urandom),
             ($urandom_range(5) == 0), 1'($urandom_range(1)));
      run_txn($sformatf("rnd_b%0d", i), 1'b1, o, a, b, 0, ref_op(o, a.val, b.val));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
